wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 RegWrite  in  1  write enable from MEM/WB stage.
REQ-004 RegDistidx  in  2  destination register index R0..R3.
REQ-005 MemToReg  in  2  writeback source select.
REQ-006 ALU_res, data_B, pc_plus1, IP  in  8 each  candidate writeback values.
REQ-007 sp_op  in  2  stack-pointer op on R3: 00 none, 01 increment, 10 decrement, 11 none.
REQ-008 ra_idx, rb_idx  in  2 each  read port indices.
REQ-009 ra_data, rb_data  out  8 each  read port data.
REQ-010 sp_out  out  8  current R3 value.
REQ-011 wb_data  out  8  selected writeback value, combinational.
REQ-012 fwd_valid  out  1  registered copy of the previous cycle's effective write enable.
REQ-013 fwd_idx  out  2  registered copy of the previous cycle's write index.
REQ-014 fwd_data  out  8  registered copy of the previous cycle's write data.

Function
REQ-015 wb_data SHALL be ALU_res for MemToReg 00, data_B for 01, pc_plus1 for 10 and IP for 11.
REQ-016 The register file SHALL hold four 8-bit registers, R0..R3, with R3 acting as stack pointer.
REQ-017 When RegWrite=1, the clock edge SHALL load wb_data into R[RegDistidx].
REQ-018 When sp_op=01, the edge SHALL load R3+1 into R3, modulo 256 (FF->00).
REQ-019 When sp_op=10, the edge SHALL load R3-1 into R3, modulo 256 (00->FF).
REQ-020 When RegWrite=1 with RegDistidx=3 and sp_op is inc or dec in the same cycle, the RegWrite value SHALL win and the sp_op SHALL be discarded.
REQ-021 When RegWrite targets R0..R2 while sp_op is active, both updates SHALL occur on the same edge.
REQ-022 ra_data and rb_data SHALL be combinational reads of the stored value, giving 0-cycle read latency, unless REQ-031 applies.
REQ-023 sp_out SHALL always equal stored R3.
REQ-024 On each edge, fwd_valid SHALL load 1 if RegWrite=1 or sp_op is inc/dec, and 0 otherwise.
REQ-025 On each edge, fwd_idx SHALL load RegDistidx if RegWrite=1, 3 if only an SP op occurred, and its previous value otherwise.
REQ-026 fwd_data SHALL load the value actually written to fwd_idx, and hold its previous value when nothing is written.
REQ-027 Inputs on MemToReg, RegDistidx and the data ports SHALL have no effect when RegWrite=0, apart from wb_data.

Reset
REQ-028 While rst=1, R0, R1 and R2 SHALL be 00 and R3 SHALL be FF, independent of clk.
REQ-029 While rst=1, fwd_valid, fwd_idx and fwd_data SHALL be 0.
REQ-030 Reset asserted mid-cycle SHALL override any pending write, and the first write SHALL occur on the first rising edge after rst deasserts.

Configuration
REQ-031 With macro WB_BYPASS_EN defined, a read whose index equals the register being written this cycle SHALL return the value that will be written at the next edge (write-first).
- This covers RegDistidx writes and the R3 sp_op result.
- Priority follows REQ-020.
- sp_out is not bypassed.
REQ-032 Without WB_BYPASS_EN, reads SHALL return the stored value only (read-before-write), and no bypass logic SHALL be present.

Verification
REQ-033 Reset value check: assert rst with no clock edge -> R0..R2=00, sp_out=FF, fwd_valid=0.
REQ-034 Writeback select: RegWrite=1, RegDistidx=1, MemToReg=10, pc_plus1=3C -> after edge, rb_idx=1 reads 3C, fwd_valid=1, fwd_idx=1, fwd_data=3C.
REQ-035 SP wrap:
- From reset, sp_op=01 -> sp_out=00.
- Then sp_op=10 twice -> sp_out=FF, then FE.
REQ-036 Collision:
- RegWrite=1, RegDistidx=3, MemToReg=00, ALU_res=80, sp_op=10 -> sp_out=80 after the edge.
- Same cycle with RegDistidx=2 -> R2=80 and R3 decremented.
REQ-037 Bypass: RegWrite=1, RegDistidx=0, data_B=5A, MemToReg=01, ra_idx=0, reading before the edge.
- With WB_BYPASS_EN: ra_data=5A.
- Without WB_BYPASS_EN: ra_data=00.
REQ-038 Mid-operation reset: pulse rst between edges after writing R1=77 -> R1 reads 00 immediately; the next edge with RegWrite=0 leaves R1=00.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: four-entry 8-bit register file for the MEM/WB stage.
// R3 doubles as the stack pointer and can be incremented or decremented
// by sp_op on the same edge as an ordinary writeback to another register.
// A registered copy of the last effective write (fwd_*) is provided for
// downstream forwarding.
//
// Build option: define WB_BYPASS_EN to make the read ports write-first
// (a read of the register being written this cycle returns the value that
// will be stored at the next edge). sp_out is never bypassed. Without the
// macro the read ports return the stored value only.

module wb_regfile (
  input  logic       clk,
  input  logic       rst,
  input  logic       RegWrite,
  input  logic [1:0] RegDistidx,
  input  logic [1:0] MemToReg,
  input  logic [7:0] ALU_res,
  input  logic [7:0] data_B,
  input  logic [7:0] pc_plus1,
  input  logic [7:0] IP,
  input  logic [1:0] sp_op,
  input  logic [1:0] ra_idx,
  input  logic [1:0] rb_idx,
  output logic [7:0] ra_data,
  output logic [7:0] rb_data,
  output logic [7:0] sp_out,
  output logic [7:0] wb_data,
  output logic       fwd_valid,
  output logic [1:0] fwd_idx,
  output logic [7:0] fwd_data
);

  localparam logic [1:0] SP_IDX  = 2'd3;
  localparam logic [1:0] SP_NONE = 2'b00;
  localparam logic [1:0] SP_INC  = 2'b01;
  localparam logic [1:0] SP_DEC  = 2'b10;

  // Architectural state
  logic [7:0] regs_r [0:3];
  logic       fwd_valid_r;
  logic [1:0] fwd_idx_r;
  logic [7:0] fwd_data_r;

  // Next-state helpers
  logic [7:0] wb_data_s;
  logic       sp_active_s;
  logic [7:0] sp_next_s;
  logic       sp_wr_s;
  logic [3:0] reg_we_s;
  logic [7:0] reg_nxt_s [0:3];
  logic       fwd_valid_s;
  logic [1:0] fwd_idx_s;
  logic [7:0] fwd_data_s;

  // Writeback source multiplexer
  always_comb begin
    wb_data_s = ALU_res;
    case (MemToReg)
      2'b00:   wb_data_s = ALU_res;
      2'b01:   wb_data_s = data_B;
      2'b10:   wb_data_s = pc_plus1;
      2'b11:   wb_data_s = IP;
      default: wb_data_s = ALU_res;
    endcase
  end

  assign wb_data = wb_data_s;

  // Stack-pointer arithmetic on R3 (8-bit wrap in both directions)
  always_comb begin
    sp_active_s = 1'b0;
    sp_next_s   = regs_r[3];
    case (sp_op)
      SP_INC: begin
        sp_active_s = 1'b1;
        sp_next_s   = regs_r[3] + 8'd1;
      end
      SP_DEC: begin
        sp_active_s = 1'b1;
        sp_next_s   = regs_r[3] - 8'd1;
      end
      SP_NONE: begin
        sp_active_s = 1'b0;
        sp_next_s   = regs_r[3];
      end
      default: begin
        sp_active_s = 1'b0;
        sp_next_s   = regs_r[3];
      end
    endcase
  end

  // A writeback aimed at R3 takes priority over the stack-pointer op
  always_comb begin
    if (sp_active_s && !(RegWrite && (RegDistidx == SP_IDX))) begin
      sp_wr_s = 1'b1;
    end else begin
      sp_wr_s = 1'b0;
    end
  end

  // Per-register write enable and next value; shared by the update and bypass paths
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      reg_we_s[i]  = 1'b0;
      reg_nxt_s[i] = regs_r[i];
    end
    if (RegWrite) begin
      reg_we_s[RegDistidx]  = 1'b1;
      reg_nxt_s[RegDistidx] = wb_data_s;
    end else begin
      reg_we_s[RegDistidx]  = 1'b0;
    end
    if (sp_wr_s) begin
      reg_we_s[3]  = 1'b1;
      reg_nxt_s[3] = sp_next_s;
    end else begin
      reg_we_s[3]  = reg_we_s[3];
    end
  end

  // Forwarding record: the writeback wins the report, otherwise the SP op, otherwise hold
  always_comb begin
    fwd_valid_s = RegWrite | sp_active_s;
    if (RegWrite) begin
      fwd_idx_s  = RegDistidx;
      fwd_data_s = wb_data_s;
    end else if (sp_active_s) begin
      fwd_idx_s  = SP_IDX;
      fwd_data_s = sp_next_s;
    end else begin
      fwd_idx_s  = fwd_idx_r;
      fwd_data_s = fwd_data_r;
    end
  end

  // Register array update; reset forces R0..R2 to 00 and the stack pointer to FF
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_r[0] <= 8'h00;
      regs_r[1] <= 8'h00;
      regs_r[2] <= 8'h00;
      regs_r[3] <= 8'hFF;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (reg_we_s[i]) begin
          regs_r[i] <= reg_nxt_s[i];
        end
      end
    end
  end

  // Forwarding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_valid_r <= 1'b0;
      fwd_idx_r   <= 2'd0;
      fwd_data_r  <= 8'h00;
    end else begin
      fwd_valid_r <= fwd_valid_s;
      fwd_idx_r   <= fwd_idx_s;
      fwd_data_r  <= fwd_data_s;
    end
  end

  assign fwd_valid = fwd_valid_r;
  assign fwd_idx   = fwd_idx_r;
  assign fwd_data  = fwd_data_r;
  assign sp_out    = regs_r[3];

`ifdef WB_BYPASS_EN
  // Write-first read ports: return the pending write value when indices match
  always_comb begin
    if (reg_we_s[ra_idx]) begin
      ra_data = reg_nxt_s[ra_idx];
    end else begin
      ra_data = regs_r[ra_idx];
    end
    if (reg_we_s[rb_idx]) begin
      rb_data = reg_nxt_s[rb_idx];
    end else begin
      rb_data = regs_r[rb_idx];
    end
  end
`else
  // Read-before-write ports: stored value only
  assign ra_data = regs_r[ra_idx];
  assign rb_data = regs_r[rb_idx];
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile. Expected values are
// hand-computed constants; bypass expectations follow WB_BYPASS_EN.

module tb_wb_regfile;

  logic       clk;
  logic       rst;
  logic       RegWrite;
  logic [1:0] RegDistidx;
  logic [1:0] MemToReg;
  logic [7:0] ALU_res;
  logic [7:0] data_B;
  logic [7:0] pc_plus1;
  logic [7:0] IP;
  logic [1:0] sp_op;
  logic [1:0] ra_idx;
  logic [1:0] rb_idx;
  logic [7:0] ra_data;
  logic [7:0] rb_data;
  logic [7:0] sp_out;
  logic [7:0] wb_data;
  logic       fwd_valid;
  logic [1:0] fwd_idx;
  logic [7:0] fwd_data;

  int n_checks;
  int n_fail;

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .RegWrite   (RegWrite),
    .RegDistidx (RegDistidx),
    .MemToReg   (MemToReg),
    .ALU_res    (ALU_res),
    .data_B     (data_B),
    .pc_plus1   (pc_plus1),
    .IP         (IP),
    .sp_op      (sp_op),
    .ra_idx     (ra_idx),
    .rb_idx     (rb_idx),
    .ra_data    (ra_data),
    .rb_data    (rb_data),
    .sp_out     (sp_out),
    .wb_data    (wb_data),
    .fwd_valid  (fwd_valid),
    .fwd_idx    (fwd_idx),
    .fwd_data   (fwd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_pair(input logic [1:0] a, input logic [1:0] b);
    ra_idx = a;
    rb_idx = b;
    #1;
  endtask

  logic [7:0] exp_byp_a;
  logic [7:0] exp_byp_b;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    RegWrite   = 1'b0;
    RegDistidx = 2'd0;
    MemToReg   = 2'd0;
    ALU_res    = 8'h11;
    data_B     = 8'h22;
    pc_plus1   = 8'h33;
    IP         = 8'h44;
    sp_op      = 2'b00;
    ra_idx     = 2'd0;
    rb_idx     = 2'd1;

    // Reset values before any clock edge
    #2;
    check_eq("rst_r0", ra_data, 8'h00);
    check_eq("rst_r1", rb_data, 8'h00);
    read_pair(2'd2, 2'd3);
    check_eq("rst_r2", ra_data, 8'h00);
    check_eq("rst_r3", rb_data, 8'hFF);
    check_eq("rst_sp", sp_out, 8'hFF);
    check_eq("rst_fwd_valid", {7'd0, fwd_valid}, 8'h00);
    check_eq("rst_fwd_idx", {6'd0, fwd_idx}, 8'h00);
    check_eq("rst_fwd_data", fwd_data, 8'h00);

    @(negedge clk);
    rst = 1'b0;

    // Writeback select pc_plus1 into R1
    RegWrite   = 1'b1;
    RegDistidx = 2'd1;
    MemToReg   = 2'b10;
    pc_plus1   = 8'h3C;
    #1;
    check_eq("wb_sel_pc", wb_data, 8'h3C);
    step();
    RegWrite = 1'b0;
    read_pair(2'd0, 2'd1);
    check_eq("wr_r1", rb_data, 8'h3C);
    check_eq("wr_r0_untouched", ra_data, 8'h00);
    check_eq("wr_fwd_valid", {7'd0, fwd_valid}, 8'h01);
    check_eq("wr_fwd_idx", {6'd0, fwd_idx}, 8'h01);
    check_eq("wr_fwd_data", fwd_data, 8'h3C);

    // Remaining writeback sources
    MemToReg = 2'b00; #1; check_eq("wb_sel_alu", wb_data, 8'h11);
    MemToReg = 2'b01; #1; check_eq("wb_sel_b", wb_data, 8'h22);
    MemToReg = 2'b11; #1; check_eq("wb_sel_ip", wb_data, 8'h44);

    // Idle edge: data inputs ignored, fwd record holds index/data
    RegDistidx = 2'd1;
    step();
    read_pair(2'd0, 2'd1);
    check_eq("idle_r1", rb_data, 8'h3C);
    check_eq("idle_fwd_valid", {7'd0, fwd_valid}, 8'h00);
    check_eq("idle_fwd_idx", {6'd0, fwd_idx}, 8'h01);
    check_eq("idle_fwd_data", fwd_data, 8'h3C);

    // Stack pointer wrap
    sp_op = 2'b01;
    step();
    check_eq("sp_inc_wrap", sp_out, 8'h00);
    check_eq("sp_inc_fwd_valid", {7'd0, fwd_valid}, 8'h01);
    check_eq("sp_inc_fwd_idx", {6'd0, fwd_idx}, 8'h03);
    check_eq("sp_inc_fwd_data", fwd_data, 8'h00);
    sp_op = 2'b10;
    step();
    check_eq("sp_dec_wrap", sp_out, 8'hFF);
    step();
    check_eq("sp_dec", sp_out, 8'hFE);
    sp_op = 2'b11;
    step();
    check_eq("sp_nop11", sp_out, 8'hFE);
    check_eq("sp_nop11_fwd_valid", {7'd0, fwd_valid}, 8'h00);

    // Collision: writeback to R3 beats decrement
    RegWrite   = 1'b1;
    RegDistidx = 2'd3;
    MemToReg   = 2'b00;
    ALU_res    = 8'h80;
    sp_op      = 2'b10;
    step();
    check_eq("coll_sp", sp_out, 8'h80);
    check_eq("coll_fwd_idx", {6'd0, fwd_idx}, 8'h03);
    check_eq("coll_fwd_data", fwd_data, 8'h80);

    // Writeback to R2 alongside decrement: both happen
    RegDistidx = 2'd2;
    step();
    RegWrite = 1'b0;
    sp_op    = 2'b00;
    read_pair(2'd2, 2'd3);
    check_eq("dual_r2", ra_data, 8'h80);
    check_eq("dual_sp", sp_out, 8'h7F);
    check_eq("dual_fwd_idx", {6'd0, fwd_idx}, 8'h02);
    check_eq("dual_fwd_data", fwd_data, 8'h80);

    // Same-cycle read of registers being written
`ifdef WB_BYPASS_EN
    exp_byp_a = 8'h5A;
    exp_byp_b = 8'h80;
`else
    exp_byp_a = 8'h00;
    exp_byp_b = 8'h7F;
`endif
    RegWrite   = 1'b1;
    RegDistidx = 2'd0;
    MemToReg   = 2'b01;
    data_B     = 8'h5A;
    sp_op      = 2'b01;
    read_pair(2'd0, 2'd3);
    check_eq("byp_ra", ra_data, exp_byp_a);
    check_eq("byp_rb_sp", rb_data, exp_byp_b);
    check_eq("byp_sp_out", sp_out, 8'h7F);
    step();
    RegWrite = 1'b0;
    sp_op    = 2'b00;
    #1;
    check_eq("post_byp_r0", ra_data, 8'h5A);
    check_eq("post_byp_sp", sp_out, 8'h80);

    // Mid-cycle reset after writing R1=77
    RegWrite   = 1'b1;
    RegDistidx = 2'd1;
    MemToReg   = 2'b00;
    ALU_res    = 8'h77;
    step();
    RegWrite = 1'b0;
    read_pair(2'd0, 2'd1);
    check_eq("pre_rst_r1", rb_data, 8'h77);
    RegWrite = 1'b1;
    ALU_res  = 8'h99;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_r1", rb_data, 8'h00);
    check_eq("mid_rst_r0", ra_data, 8'h00);
    check_eq("mid_rst_sp", sp_out, 8'hFF);
    check_eq("mid_rst_fwd_valid", {7'd0, fwd_valid}, 8'h00);
    check_eq("mid_rst_fwd_data", fwd_data, 8'h00);
    RegWrite = 1'b0;
    #1;
    rst = 1'b0;
    step();
    check_eq("post_rst_r1", rb_data, 8'h00);
    check_eq("post_rst_fwd_valid", {7'd0, fwd_valid}, 8'h00);

    // First write after reset lands on the next edge
    RegWrite = 1'b1;
    ALU_res  = 8'hAB;
    step();
    RegWrite = 1'b0;
    #1;
    check_eq("first_wr_r1", rb_data, 8'hAB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
